// File: rtl/lieat_pipe_pkg.sv
// Shared definitions for lieat pipeline stage boundaries: skid state encoding and boot vector.
package lieat_pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

  localparam logic [31:0] BOOT_VECTOR = 32'h8000_0000;

endpackage

// File: rtl/lieat_pipe_skid_dff.sv
// General-purpose flop primitives: load-enable with reset-to-default, without reset,
// and with reset-to-zero. All resets are asynchronous active-low.
module lieat_general_dffrd #(
  parameter int              DW      = 32,
  parameter logic [DW-1:0]   DEFAULT = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     qout <= DEFAULT;
    else if (lden) qout <= dnxt;
  end
endmodule

module lieat_general_dffl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) begin
    if (lden) qout <= dnxt;
  end
endmodule

module lieat_general_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     qout <= '0;
    else if (lden) qout <= dnxt;
  end
endmodule

// File: rtl/lieat_pipe_skid.sv
// Registered valid/ready stage boundary with a one-beat skid buffer (full throughput).
// Optional pipeline kill input enabled by defining LIEAT_PIPE_FLUSH_EN.
module lieat_pipe_skid
  import lieat_pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] RST_DATA = BOOT_VECTOR
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data
`ifdef LIEAT_PIPE_FLUSH_EN
  ,
  input  logic          flush
`endif
);

  logic [1:0]    state_q;
  pipe_state_e   state_next;
  logic          main_ld;
  logic [DW-1:0] main_d;
  logic          skid_ld;
  logic [DW-1:0] skid_q;
  logic          kill;
  logic          in_xfer;
  logic          out_xfer;

`ifdef LIEAT_PIPE_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // Encoding makes bit 0 "main valid" and bit 1 "skid valid", so both handshake
  // outputs come straight off the state register.
  assign o_valid  = state_q[0];
  assign i_ready  = ~state_q[1];
  assign in_xfer  = i_valid & i_ready;
  assign out_xfer = o_valid & o_ready;

  always_comb begin
    state_next = pipe_state_e'(state_q);
    main_ld    = 1'b0;
    main_d     = i_data;
    skid_ld    = 1'b0;
    case (pipe_state_e'(state_q))
      ST_EMPTY: begin
        if (in_xfer) begin
          main_ld    = 1'b1;
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          main_ld = 1'b1;
        end else if (in_xfer) begin
          skid_ld    = 1'b1;
          state_next = ST_FULL;
        end else if (out_xfer) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_ld    = 1'b1;
          main_d     = skid_q;
          state_next = ST_BUSY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
    // Kill wins over every transfer; o_data is deliberately left untouched.
    if (kill) begin
      state_next = ST_EMPTY;
      main_ld    = 1'b0;
      skid_ld    = 1'b0;
    end
  end

  lieat_general_dffrd #(.DW(DW), .DEFAULT(DW'(RST_DATA))) u_main (
    .clk  (clk),
    .rstn (rstn),
    .lden (main_ld),
    .dnxt (main_d),
    .qout (o_data)
  );

  lieat_general_dffl #(.DW(DW)) u_skid (
    .clk  (clk),
    .lden (skid_ld),
    .dnxt (i_data),
    .qout (skid_q)
  );

  lieat_general_dfflr #(.DW(2)) u_state (
    .clk  (clk),
    .rstn (rstn),
    .lden (1'b1),
    .dnxt (state_next),
    .qout (state_q)
  );

endmodule

// File: tb/tb_lieat_pipe_skid.sv
// Directed and random self-checking bench for lieat_pipe_skid (flush steps need LIEAT_PIPE_FLUSH_EN).
module tb_lieat_pipe_skid;

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        o_ready;
  logic [31:0] o_data;
`ifdef LIEAT_PIPE_FLUSH_EN
  logic        flush;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lieat_pipe_skid #(.DW(32), .RST_DATA(32'h8000_0000)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_data  (o_data)
`ifdef LIEAT_PIPE_FLUSH_EN
    ,
    .flush   (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] sb[$];
  logic [31:0] seq_val;
  logic [31:0] exp_data;
  bit          in_x;
  bit          out_x;

  initial begin
    rstn    = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    o_ready = 1'b0;
`ifdef LIEAT_PIPE_FLUSH_EN
    flush   = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_i_ready", 32'(i_ready), 32'd1);
    check("rst_o_data", o_data, 32'h8000_0000);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    tick();
    check("idle_o_valid", 32'(o_valid), 32'd0);
    check("idle_i_ready", 32'(i_ready), 32'd1);
    check("idle_o_data", o_data, 32'h8000_0000);

    // Streaming: 8 back-to-back beats
    o_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      i_valid = 1'b1;
      i_data  = 32'(k);
      check($sformatf("stream_i_ready_%0d", k), 32'(i_ready), 32'd1);
      tick();
      check($sformatf("stream_o_valid_%0d", k), 32'(o_valid), 32'd1);
      check($sformatf("stream_o_data_%0d", k), o_data, 32'(k));
    end
    i_valid = 1'b0;
    tick();
    check("stream_drain_o_valid", 32'(o_valid), 32'd0);
    check("stream_hold_o_data", o_data, 32'h8);

    // Backpressure: 0xA then 0xB with o_ready low
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hA;
    tick();
    check("bp_a_o_data", o_data, 32'hA);
    check("bp_a_i_ready", 32'(i_ready), 32'd1);
    i_data = 32'hB;
    tick();
    i_valid = 1'b0;
    check("bp_full_i_ready", 32'(i_ready), 32'd0);
    check("bp_full_o_data", o_data, 32'hA);
    check("bp_full_o_valid", 32'(o_valid), 32'd1);
    tick();
    check("bp_stall_o_data", o_data, 32'hA);
    o_ready = 1'b1;
    tick();
    check("bp_b_o_data", o_data, 32'hB);
    check("bp_b_o_valid", 32'(o_valid), 32'd1);
    check("bp_b_i_ready", 32'(i_ready), 32'd1);
    tick();
    check("bp_empty_o_valid", 32'(o_valid), 32'd0);

    // Random valid/ready with scoreboard
    seq_val = 32'h1000;
    i_valid = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!i_valid) begin
        i_valid = ($urandom_range(0, 1) == 1);
        if (i_valid) begin
          i_data  = seq_val;
          seq_val = seq_val + 1;
        end
      end
      o_ready = ($urandom_range(0, 1) == 1);
      #1;
      check("rnd_i_ready", 32'(i_ready), 32'(sb.size() < 2));
      check("rnd_o_valid", 32'(o_valid), 32'(sb.size() > 0));
      in_x  = i_valid & i_ready;
      out_x = o_valid & o_ready;
      if (out_x) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL rnd_underflow observed=%h expected=none", o_data);
        end else begin
          exp_data = sb.pop_front();
          check("rnd_o_data", o_data, exp_data);
        end
      end
      if (in_x) sb.push_back(i_data);
      tick();
      if (in_x) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (o_valid && sb.size() > 0) begin
        exp_data = sb.pop_front();
        check("rnd_drain_o_data", o_data, exp_data);
      end
      tick();
    end
    check("rnd_leftover", 32'(sb.size()), 32'd0);
    check("rnd_final_o_valid", 32'(o_valid), 32'd0);

`ifdef LIEAT_PIPE_FLUSH_EN
    // Flush from FULL holding 0xC,0xD with 0xE offered
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'hC;
    tick();
    i_data = 32'hD;
    tick();
    check("fl_pre_i_ready", 32'(i_ready), 32'd0);
    i_data = 32'hE;
    flush  = 1'b1;
    tick();
    flush   = 1'b0;
    i_valid = 1'b0;
    check("fl_o_valid", 32'(o_valid), 32'd0);
    check("fl_i_ready", 32'(i_ready), 32'd1);
    o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fl_stays_empty", 32'(o_valid), 32'd0);
    end
`endif

    // Async reset while FULL, between clock edges
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_data  = 32'h21;
    tick();
    i_data = 32'h22;
    tick();
    i_valid = 1'b0;
    check("ar_pre_i_ready", 32'(i_ready), 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_o_valid", 32'(o_valid), 32'd0);
    check("ar_i_ready", 32'(i_ready), 32'd1);
    check("ar_o_data", o_data, 32'h8000_0000);
    @(negedge clk);
    rstn = 1'b1;
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = 32'h55;
    tick();
    i_valid = 1'b0;
    check("ar_after_o_valid", 32'(o_valid), 32'd1);
    check("ar_after_o_data", o_data, 32'h55);
    tick();
    check("ar_after_drain", 32'(o_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
